sdp_ram_fifo_ctrl: RTL



---
 rtl/sdp_ram_fifo_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sdp_ram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external simple dual-port RAM with a 2-entry FWFT skid buffer.
// Define SDP_FIFO_CTRL_STATUS_EN to add occupancy, almost_full and err_ovf status outputs.
module sdp_ram_fifo_ctrl #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
`ifdef SDP_FIFO_CTRL_STATUS_EN
    ,
    parameter int AFULL_THRESH = (1 << ADDR_BITS) - 2
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDR_BITS-1:0] ram_addra,
    output logic [DATA_BITS-1:0] ram_dia,
    output logic                 ram_enb,
    output logic [ADDR_BITS-1:0] ram_addrb,
    input  logic [DATA_BITS-1:0] ram_dob
`ifdef SDP_FIFO_CTRL_STATUS_EN
    ,
    output logic [ADDR_BITS+1:0] occupancy,
    output logic                 almost_full,
    output logic                 err_ovf
`endif
);

    localparam int PTR_BITS = ADDR_BITS + 1;
    localparam logic [PTR_BITS-1:0] DEPTH = PTR_BITS'(1 << ADDR_BITS);

    // Encoding doubles as the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } obuf_state_e;

    obuf_state_e          state_q, state_d;
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic                 rd_inflight_q, rd_inflight_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic [DATA_BITS-1:0] tail_q, tail_d;

    logic [PTR_BITS-1:0]  ram_cnt;
    logic [1:0]           obuf_cnt;
    logic [2:0]           held;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 cap;

    always_comb begin
        ram_cnt  = wr_ptr_q - rd_ptr_q;
        obuf_cnt = state_q;
        held     = {1'b0, obuf_cnt} + {2'b00, rd_inflight_q};
        in_ready = !rst && (ram_cnt != DEPTH);
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        // Issue only if the skid buffer can absorb the word after this cycle's pop.
        issue    = !rst && (ram_cnt != '0) && (held < (3'd2 + {2'b00, pop}));
        cap      = rd_inflight_q;
    end

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wr_ptr_q[ADDR_BITS-1:0];
    assign ram_dia   = in_data;
    assign ram_enb   = issue;
    assign ram_addrb = rd_ptr_q[ADDR_BITS-1:0];
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        rd_inflight_d = issue;
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
        case (state_q)
            EMPTY: begin
                if (cap) begin
                    state_d = ONE;
                    head_d  = ram_dob;
                end
            end
            ONE: begin
                if (cap && pop) begin
                    head_d = ram_dob;
                end else if (cap) begin
                    state_d = TWO;
                    tail_d  = ram_dob;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (cap) tail_d = ram_dob;
                    else state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_inflight_q <= rd_inflight_d;
        end
        head_q <= head_d;
        tail_q <= tail_d;
    end

`ifdef SDP_FIFO_CTRL_STATUS_EN
    localparam int OCC_BITS = ADDR_BITS + 2;
    localparam logic [OCC_BITS-1:0] AFULL_V = OCC_BITS'(AFULL_THRESH);

    logic [OCC_BITS-1:0] occupancy_q, occupancy_d;
    logic                almost_full_q, almost_full_d;
    logic                err_ovf_q, err_ovf_d;
    logic [PTR_BITS-1:0] ram_cnt_next;

    // Built from next-state values so the registered count tracks the current state.
    always_comb begin
        ram_cnt_next  = wr_ptr_d - rd_ptr_d;
        occupancy_d   = OCC_BITS'(ram_cnt_next) + OCC_BITS'(state_d) + OCC_BITS'(rd_inflight_d);
        almost_full_d = (occupancy_d >= AFULL_V);
        err_ovf_d     = err_ovf_q || (in_valid && !in_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_q   <= '0;
            almost_full_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            occupancy_q   <= occupancy_d;
            almost_full_q <= almost_full_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    assign occupancy   = occupancy_q;
    assign almost_full = almost_full_q;
    assign err_ovf     = err_ovf_q;
`endif

endmodule
